// File: rtl/alu_issue_ctrl_pkg.sv
// Shared widths, ALU opcode constants and controller state type for the ALU issue path.
package alu_issue_ctrl_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int ALU_OPRN_WIDTH = 6;

    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_NOP = 6'h00;
    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_ADD = 6'h01;
    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_SUB = 6'h02;
    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_MUL = 6'h03;
    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_SHR = 6'h04;
    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_SHL = 6'h05;
    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_AND = 6'h06;
    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_OR  = 6'h07;
    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_NOR = 6'h08;
    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_DIV = 6'h09;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_op_classify.sv
// Decodes an ALU opcode into legal / multi-cycle flags; shared with the control unit.
module alu_op_classify
    import alu_issue_ctrl_pkg::*;
(
    input  logic [ALU_OPRN_WIDTH-1:0] OPRN,
    output logic                      is_legal,
    output logic                      is_multi
);

    always_comb begin
        is_legal = 1'b0;
        is_multi = 1'b0;
        case (OPRN)
            ALU_OPRN_ADD, ALU_OPRN_SUB, ALU_OPRN_AND,
            ALU_OPRN_OR,  ALU_OPRN_NOR: is_legal = 1'b1;
            ALU_OPRN_MUL, ALU_OPRN_SHR,
            ALU_OPRN_SHL, ALU_OPRN_DIV: begin
                is_legal = 1'b1;
                is_multi = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one operation at a time to the multi-cycle ALU and returns the captured
// result (or a timeout / illegal-opcode error) on a valid/ready response channel.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      REQ_VALID,
    output logic                      REQ_READY,
    input  logic [DATA_WIDTH-1:0]     REQ_OP1,
    input  logic [DATA_WIDTH-1:0]     REQ_OP2,
    input  logic [ALU_OPRN_WIDTH-1:0] REQ_OPRN,
    output logic [DATA_WIDTH-1:0]     ALU_OP1,
    output logic [DATA_WIDTH-1:0]     ALU_OP2,
    output logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN,
    input  logic [DATA_WIDTH-1:0]     ALU_OUTLOW,
    input  logic [DATA_WIDTH-1:0]     ALU_OUTHIGH,
    input  logic                      ALU_DONE,
    output logic                      RSP_VALID,
    input  logic                      RSP_READY,
    output logic [DATA_WIDTH-1:0]     RSP_LOW,
    output logic [DATA_WIDTH-1:0]     RSP_HIGH,
    output logic                      RSP_ZERO,
    output logic                      RSP_ERR,
    output logic                      BUSY
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e                      state_q, state_d;
    logic [7:0]                  cnt_q, cnt_d;
    logic                        multi_q, multi_d;
    logic [DATA_WIDTH-1:0]       op1_q, op1_d, op2_q, op2_d;
    logic [ALU_OPRN_WIDTH-1:0]   oprn_q, oprn_d;
    logic [DATA_WIDTH-1:0]       low_q, low_d, high_q, high_d;
    logic                        zero_q, zero_d, err_q, err_d;
    logic                        req_legal, req_multi;

    alu_op_classify u_classify (
        .OPRN     (REQ_OPRN),
        .is_legal (req_legal),
        .is_multi (req_multi)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        multi_d = multi_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        oprn_d  = oprn_q;
        low_d   = low_q;
        high_d  = high_q;
        zero_d  = zero_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (REQ_VALID) begin
                    // Illegal opcodes still spend one EXEC cycle with ALU_OPRN at NOP,
                    // which is how EXEC recognises them and keeps response latency at one.
                    op1_d   = REQ_OP1;
                    op2_d   = REQ_OP2;
                    oprn_d  = req_legal ? REQ_OPRN : ALU_OPRN_NOP;
                    multi_d = req_multi;
                    cnt_d   = 8'd0;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                cnt_d = cnt_q + 8'd1;
                if (oprn_q == ALU_OPRN_NOP) begin
                    low_d   = '0;
                    high_d  = '0;
                    zero_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else if (!multi_q || (cnt_q != 8'd0 && ALU_DONE)) begin
                    // DONE is ignored at c==0 since it may still be asserted from the previous op.
                    low_d   = ALU_OUTLOW;
                    high_d  = (oprn_q == ALU_OPRN_MUL) ? ALU_OUTHIGH : '0;
                    zero_d  = (ALU_OUTLOW == '0);
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    low_d   = '0;
                    high_d  = '0;
                    zero_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
                if (state_d == ST_RESP) begin
                    oprn_d = ALU_OPRN_NOP;
                    cnt_d  = 8'd0;
                end
            end
            ST_RESP: begin
                if (RSP_READY) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            multi_q <= 1'b0;
            op1_q   <= '0;
            op2_q   <= '0;
            oprn_q  <= ALU_OPRN_NOP;
            low_q   <= '0;
            high_q  <= '0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            multi_q <= multi_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            oprn_q  <= oprn_d;
            low_q   <= low_d;
            high_q  <= high_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end

    assign REQ_READY = (state_q == ST_IDLE);
    assign BUSY      = (state_q != ST_IDLE);
    assign RSP_VALID = (state_q == ST_RESP);
    assign ALU_OP1   = op1_q;
    assign ALU_OP2   = op2_q;
    assign ALU_OPRN  = oprn_q;
    assign RSP_LOW   = low_q;
    assign RSP_HIGH  = high_q;
    assign RSP_ZERO  = zero_q;
    assign RSP_ERR   = err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed and randomized checks of alu_issue_ctrl against an ALU model and a
// transaction-level expectation of latency, result and error per request.
module tb_alu_issue_ctrl;
    import alu_issue_ctrl_pkg::*;

    localparam int T = 8;

    logic        CLK = 1'b0;
    logic        RST;
    logic        REQ_VALID, REQ_READY;
    logic [31:0] REQ_OP1, REQ_OP2;
    logic [5:0]  REQ_OPRN;
    logic [31:0] ALU_OP1, ALU_OP2;
    logic [5:0]  ALU_OPRN;
    logic [31:0] ALU_OUTLOW, ALU_OUTHIGH;
    logic        ALU_DONE;
    logic        RSP_VALID, RSP_READY;
    logic [31:0] RSP_LOW, RSP_HIGH;
    logic        RSP_ZERO, RSP_ERR, BUSY;

    int total = 0;
    int bad   = 0;

    alu_issue_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_OP1(REQ_OP1), .REQ_OP2(REQ_OP2), .REQ_OPRN(REQ_OPRN),
        .ALU_OP1(ALU_OP1), .ALU_OP2(ALU_OP2), .ALU_OPRN(ALU_OPRN),
        .ALU_OUTLOW(ALU_OUTLOW), .ALU_OUTHIGH(ALU_OUTHIGH), .ALU_DONE(ALU_DONE),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
        .RSP_LOW(RSP_LOW), .RSP_HIGH(RSP_HIGH), .RSP_ZERO(RSP_ZERO),
        .RSP_ERR(RSP_ERR), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behaviour of the ALU itself; shr/shl direction is this model's own choice.
    function automatic logic [63:0] alu_fn(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (op)
            ALU_OPRN_ADD: r = a + b;
            ALU_OPRN_SUB: r = a - b;
            ALU_OPRN_MUL: return {32'h0, a} * {32'h0, b};
            ALU_OPRN_SHR: r = a >> b[4:0];
            ALU_OPRN_SHL: r = a << b[4:0];
            ALU_OPRN_AND: r = a & b;
            ALU_OPRN_OR:  r = a | b;
            ALU_OPRN_NOR: r = ~(a | b);
            ALU_OPRN_DIV: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            default:      r = 32'h0;
        endcase
        return {32'h0, r};
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"}, REQ_READY, 1);
        chk({tag, "_busy"},      BUSY, 0);
        chk({tag, "_rsp_valid"}, RSP_VALID, 0);
        chk({tag, "_rsp_err"},   RSP_ERR, 0);
        chk({tag, "_rsp_zero"},  RSP_ZERO, 0);
        chk({tag, "_alu_oprn"},  ALU_OPRN, 0);
        chk({tag, "_alu_op1"},   ALU_OP1, 0);
        chk({tag, "_alu_op2"},   ALU_OP2, 0);
        chk({tag, "_rsp_low"},   RSP_LOW, 0);
        chk({tag, "_rsp_high"},  RSP_HIGH, 0);
    endtask

    // done_at: value of the EXEC counter from which the ALU holds DONE high (>=T means never).
    task automatic do_op(input string tag, input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int done_at, input bit stale,
                         input int rdy_delay);
        bit          legal, multi, exp_err, got;
        int          exp_lat, lat;
        logic [63:0] res, exp_res;
        logic [31:0] exp_low, exp_high, hold_low;

        legal   = op inside {[6'h01:6'h09]};
        multi   = op inside {6'h03, 6'h04, 6'h05, 6'h09};
        exp_err = !legal || (multi && done_at > T - 1);
        if (!legal || !multi) exp_lat = 1;
        else if (exp_err)     exp_lat = T;
        else                  exp_lat = ((done_at < 1) ? 1 : done_at) + 1;
        exp_res  = alu_fn(op, a, b);
        exp_low  = exp_err ? 32'h0 : exp_res[31:0];
        exp_high = (!exp_err && op == ALU_OPRN_MUL) ? exp_res[63:32] : 32'h0;

        @(negedge CLK);
        REQ_VALID = 1'b1; REQ_OP1 = a; REQ_OP2 = b; REQ_OPRN = op;
        RSP_READY = (rdy_delay == 0);
        chk({tag, "_req_ready"}, REQ_READY, 1);
        @(posedge CLK); #1;
        REQ_VALID = 1'b0; REQ_OP1 = $urandom; REQ_OP2 = $urandom; REQ_OPRN = 6'($urandom);

        got = 0; lat = 0;
        for (int k = 1; k <= T + 2 && !got; k++) begin
            ALU_DONE    = ((k - 1) >= done_at) || (stale && k == 1);
            res         = alu_fn(ALU_OPRN, ALU_OP1, ALU_OP2);
            ALU_OUTLOW  = res[31:0];
            ALU_OUTHIGH = (ALU_OPRN == ALU_OPRN_MUL) ? res[63:32] : (32'hBAD0_0000 | 32'(ALU_OPRN));
            @(negedge CLK);
            chk({tag, "_exec_oprn"}, ALU_OPRN, legal ? op : 6'h0);
            if (legal) chk({tag, "_exec_op1"}, ALU_OP1, a);
            chk({tag, "_exec_busy"}, BUSY, 1);
            @(posedge CLK); #1;
            if (RSP_VALID) begin got = 1; lat = k; end
        end
        ALU_DONE = 1'b0;

        chk({tag, "_latency"},  lat, exp_lat);
        chk({tag, "_low"},      RSP_LOW, exp_low);
        chk({tag, "_high"},     RSP_HIGH, exp_high);
        chk({tag, "_zero"},     RSP_ZERO, exp_low == 32'h0);
        chk({tag, "_err"},      RSP_ERR, exp_err);
        chk({tag, "_oprn_off"}, ALU_OPRN, 0);
        chk({tag, "_rsp_rdy0"}, REQ_READY, 0);

        hold_low = RSP_LOW;
        for (int i = 0; i < rdy_delay; i++) begin
            @(posedge CLK); #1;
            chk({tag, "_hold_valid"}, RSP_VALID, 1);
            chk({tag, "_hold_low"},   RSP_LOW, hold_low);
            chk({tag, "_hold_err"},   RSP_ERR, exp_err);
            chk({tag, "_hold_rdy"},   REQ_READY, 0);
            chk({tag, "_hold_oprn"},  ALU_OPRN, 0);
        end
        RSP_READY = 1'b1;
        @(posedge CLK); #1;
        chk({tag, "_done_valid"}, RSP_VALID, 0);
        chk({tag, "_done_ready"}, REQ_READY, 1);
        chk({tag, "_done_busy"},  BUSY, 0);
        RSP_READY = 1'b0;
    endtask

    initial begin
        logic [5:0] ops [12];
        ops = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0A, 6'h3F};

        RST = 1'b0; REQ_VALID = 1'b0; REQ_OP1 = '0; REQ_OP2 = '0; REQ_OPRN = '0;
        ALU_OUTLOW = '0; ALU_OUTHIGH = '0; ALU_DONE = 1'b0; RSP_READY = 1'b0;
        #1;
        chk_reset_vals("rst0");
        repeat (3) @(posedge CLK);
        @(negedge CLK); RST = 1'b1;

        do_op("add",     ALU_OPRN_ADD, 32'd5, 32'd7, 255, 1'b0, 0);
        do_op("sub",     ALU_OPRN_SUB, 32'd9, 32'd9, 255, 1'b0, 1);
        do_op("mul",     ALU_OPRN_MUL, 32'h10000, 32'h10000, 4, 1'b1, 0);
        do_op("div_to",  ALU_OPRN_DIV, 32'd100, 32'd3, 255, 1'b0, 0);
        do_op("ill0f",   6'h0F, 32'h1234, 32'h5678, 255, 1'b1, 5);
        do_op("ill00",   6'h00, 32'h1, 32'h2, 255, 1'b0, 0);
        do_op("mul_edge", ALU_OPRN_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, T - 1, 1'b0, 0);
        do_op("shl_to",  ALU_OPRN_SHL, 32'h1, 32'd4, T, 1'b0, 2);
        do_op("div_fast", ALU_OPRN_DIV, 32'd100, 32'd7, 1, 1'b1, 0);

        for (int n = 0; n < 24; n++) begin
            do_op("rand", ops[$urandom_range(0, 11)], $urandom, $urandom,
                  int'($urandom_range(0, 10)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 2)));
        end

        do_op("pre_rst", ALU_OPRN_OR, 32'hF0F0_0000, 32'h0000_0F0F, 255, 1'b0, 0);
        @(negedge CLK);
        REQ_VALID = 1'b1; REQ_OP1 = 32'd6; REQ_OP2 = 32'd7; REQ_OPRN = ALU_OPRN_MUL;
        @(posedge CLK); #1;
        REQ_VALID = 1'b0; ALU_DONE = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk("mid_busy", BUSY, 1);
        #2 RST = 1'b0;
        #1 chk_reset_vals("rst_mid");
        @(negedge CLK); RST = 1'b1;
        do_op("post_rst", ALU_OPRN_ADD, 32'd40, 32'd2, 255, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
